branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is purely combinational; table writes land on the next rising edge.
module branch_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispred_i,
    output logic [15:0]       mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic              tbl_valid [ENTRIES];
    logic [TAG_W-1:0]  tbl_tag   [ENTRIES];
    logic [CNT_W-1:0]  tbl_cnt   [ENTRIES];
    logic [ADDR_W-1:0] tbl_tgt   [ENTRIES];
    logic [15:0]       mispred_cnt;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             tbl_wr;

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic up);
        if (up)
            return (&c) ? c : c + CNT_W'(1);
        else
            return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign lk_idx  = pc_i[IDX_W-1:0];
    assign lk_tag  = pc_i[ADDR_W-1:IDX_W];
    assign upd_idx = upd_pc_i[IDX_W-1:0];
    assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W];
    assign upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign pred_hit_o    = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
    assign pred_taken_o  = pred_hit_o && tbl_cnt[lk_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? tbl_tgt[lk_idx] : pc_i + ADDR_W'(1);
    assign mispred_cnt_o = mispred_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_cnt[i]   <= CNT_WNT;
            end
            mispred_cnt <= '0;
        end else begin
            if (upd_valid_i && upd_mispred_i)
                mispred_cnt <= sat_inc16(mispred_cnt);
            if (flush_i) begin
                for (int i = 0; i < ENTRIES; i++)
                    tbl_valid[i] <= 1'b0;
            end else if (upd_valid_i) begin
                if (upd_hit) begin
                    tbl_cnt[upd_idx] <= cnt_step(tbl_cnt[upd_idx], upd_taken_i);
                end else if (upd_taken_i) begin
                    tbl_valid[upd_idx] <= 1'b1;
                    tbl_cnt[upd_idx]   <= CNT_WT;
                end
            end
        end
    end

    // Tag/target storage carries no reset; it is only meaningful behind a valid bit.
    assign tbl_wr = !rst && !flush_i && upd_valid_i && upd_taken_i;

    always_ff @(posedge clk) begin
        if (tbl_wr) begin
            tbl_tag[upd_idx] <= upd_tag;
            tbl_tgt[upd_idx] <= upd_target_i;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: drivers queue expected responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [15:0] pc_i = '0;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [15:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [15:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [15:0] upd_target_i = '0;
    logic        upd_mispred_i = 1'b0;
    logic [15:0] mispred_cnt_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        kind;
        logic        hit;
        logic        taken;
        logic [15:0] target;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    branch_predictor #(.ADDR_W(16), .ENTRIES(16), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .pc_i         (pc_i),
        .pred_hit_o   (pred_hit_o),
        .pred_taken_o (pred_taken_o),
        .pred_target_o(pred_target_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .upd_mispred_i(upd_mispred_i),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (e.kind) begin
                if (mispred_cnt_o !== e.cnt) begin
                    bad++;
                    $display("FAIL %s: mispred_cnt=%h want %h", nm, mispred_cnt_o, e.cnt);
                end
            end else if (pred_hit_o !== e.hit || pred_taken_o !== e.taken || pred_target_o !== e.target) begin
                bad++;
                $display("FAIL %s: hit=%0d taken=%0d target=%h want hit=%0d taken=%0d target=%h",
                         nm, pred_hit_o, pred_taken_o, pred_target_o, e.hit, e.taken, e.target);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        upd_valid_i   = 1'b0;
        upd_mispred_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic look(input string nm, input logic [15:0] pc, input logic h,
                        input logic t, input logic [15:0] tg);
        exp_t e;
        pc_i = pc;
        e = '{kind: 1'b0, hit: h, taken: t, target: tg, cnt: 16'h0};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk_cnt(input string nm, input logic [15:0] v);
        exp_t e;
        e = '{kind: 1'b1, hit: 1'b0, taken: 1'b0, target: 16'h0, cnt: v};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tg, input logic mp);
        upd_valid_i   = 1'b1;
        upd_pc_i      = pc;
        upd_taken_i   = tk;
        upd_target_i  = tg;
        upd_mispred_i = mp;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        look("rst_lookup", 16'h0013, 1'b0, 1'b0, 16'h0014);
        chk_cnt("rst_cnt", 16'h0000);
        tick();
        look("rst_any_pc", 16'hABCD, 1'b0, 1'b0, 16'hABCE);
        tick();

        upd(16'h0013, 1'b1, 16'h0040, 1'b0);
        tick();
        look("cold_alloc", 16'h0013, 1'b1, 1'b1, 16'h0040);
        tick();

        // Counter 2 -> 1 -> 0 -> 0
        upd(16'h0013, 1'b0, 16'h0000, 1'b0);
        tick();
        look("hyst_first_nt", 16'h0013, 1'b1, 1'b0, 16'h0014);
        tick();
        upd(16'h0013, 1'b0, 16'h0000, 1'b0);
        tick();
        look("hyst_second_nt", 16'h0013, 1'b1, 1'b0, 16'h0014);
        tick();
        upd(16'h0013, 1'b0, 16'h0000, 1'b0);
        tick();
        look("sat_zero_hold", 16'h0013, 1'b1, 1'b0, 16'h0014);
        tick();

        // Counter 0 -> 1 -> 2 -> 3 -> 3 -> 3, then one not-taken leaves 2
        for (int i = 0; i < 5; i++) begin
            upd(16'h0013, 1'b1, 16'h0050, 1'b0);
            tick();
        end
        look("sat_top", 16'h0013, 1'b1, 1'b1, 16'h0050);
        tick();
        upd(16'h0013, 1'b0, 16'h0000, 1'b0);
        tick();
        look("sat_no_wrap", 16'h0013, 1'b1, 1'b1, 16'h0050);
        tick();

        upd(16'h0023, 1'b1, 16'h0100, 1'b0);
        tick();
        look("conflict_old", 16'h0013, 1'b0, 1'b0, 16'h0014);
        tick();
        look("conflict_new", 16'h0023, 1'b1, 1'b1, 16'h0100);
        tick();

        upd(16'h0033, 1'b0, 16'h0200, 1'b0);
        tick();
        look("nt_miss_keep", 16'h0023, 1'b1, 1'b1, 16'h0100);
        tick();
        look("nt_miss_noalloc", 16'h0033, 1'b0, 1'b0, 16'h0034);
        tick();

        upd(16'h0005, 1'b1, 16'h0077, 1'b0);
        look("same_cycle_old", 16'h0005, 1'b0, 1'b0, 16'h0006);
        tick();
        look("same_cycle_new", 16'h0005, 1'b1, 1'b1, 16'h0077);
        tick();

        upd_mispred_i = 1'b1;
        tick();
        chk_cnt("mp_without_valid", 16'h0000);
        tick();
        upd(16'h0044, 1'b0, 16'h0000, 1'b1);
        tick();
        chk_cnt("mp_valid", 16'h0001);
        tick();

        flush_i = 1'b1;
        upd(16'h0006, 1'b1, 16'h0099, 1'b1);
        tick();
        look("flush_a", 16'h0005, 1'b0, 1'b0, 16'h0006);
        chk_cnt("flush_still_counts", 16'h0002);
        tick();
        look("flush_b", 16'h0023, 1'b0, 1'b0, 16'h0024);
        tick();
        look("flush_drops_upd", 16'h0006, 1'b0, 1'b0, 16'h0007);
        tick();

        for (int i = 0; i < 16'hFFFD; i++) begin
            upd(16'h0044, 1'b0, 16'h0000, 1'b1);
            tick();
        end
        chk_cnt("mp_reach_max", 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            upd(16'h0044, 1'b0, 16'h0000, 1'b1);
            tick();
        end
        chk_cnt("mp_saturate", 16'hFFFF);
        tick();

        look("pc_wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);
        tick();

        upd(16'h0008, 1'b1, 16'h0123, 1'b0);
        tick();
        look("pre_rst_hit", 16'h0008, 1'b1, 1'b1, 16'h0123);
        tick();
        rst = 1'b1;
        upd(16'h0009, 1'b1, 16'h0321, 1'b1);
        tick();
        rst = 1'b0;
        look("post_rst_a", 16'h0008, 1'b0, 1'b0, 16'h0009);
        chk_cnt("post_rst_cnt", 16'h0000);
        tick();
        look("post_rst_b", 16'h0009, 1'b0, 1'b0, 16'h000A);
        tick();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
